// File: rtl/seq_sm_mul.sv
// Iterative sign-magnitude shift-add multiplier with fractional scaling, symmetric
// saturation and valid/ready handshakes on both sides.
module seq_sm_mul #(
  parameter int unsigned MAG_W     = 15,
  parameter int unsigned FRAC_BITS = 0,
  parameter int unsigned OUT_W     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] mag_a,
  input  logic             sign_a,
  input  logic [MAG_W-1:0] mag_b,
  input  logic             sign_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             sign,
  output logic             overflow
);

  localparam int unsigned PW    = 2 * MAG_W;
  localparam int unsigned CW    = (PW > OUT_W) ? PW : OUT_W;
  localparam int unsigned CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

  if (FRAC_BITS > MAG_W || OUT_W < 2) begin : g_param_err
    $error("seq_sm_mul: FRAC_BITS must be <= MAG_W and OUT_W must be >= 2");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_t;

  state_t           state;
  logic [PW-1:0]    a_sh;
  logic [MAG_W-1:0] b_sh;
  logic [PW-1:0]    acc;
  logic             neg;
  logic [CNT_W-1:0] cnt;

  logic [CW-1:0]    mag_s;
  logic [CW-1:0]    max_mag;
  logic [CW-1:0]    mag_sat;
  logic             ovf_c;
  logic [OUT_W-1:0] out_c;

  // Saturate to +/-(2^(OUT_W-1)-1) so the most negative code never appears.
  always_comb begin
    mag_s                = CW'(acc >> FRAC_BITS);
    max_mag              = '0;
    max_mag[OUT_W-2:0]   = '1;
    ovf_c                = mag_s > max_mag;
    mag_sat              = ovf_c ? max_mag : mag_s;
    out_c                = neg ? (~mag_sat[OUT_W-1:0] + OUT_W'(1)) : mag_sat[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      sign      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            a_sh     <= PW'(mag_a);
            b_sh     <= mag_b;
            neg      <= sign_a ^ sign_b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= StBusy;
          end
        end
        StBusy: begin
          // a_sh holds mag_a << cnt and b_sh[0] is multiplier bit cnt.
          if (b_sh[0]) acc <= acc + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MAG_W - 1)) state <= StFix;
        end
        StFix: begin
          out       <= out_c;
          sign      <= neg && (mag_sat != '0);
          overflow  <= ovf_c;
          out_valid <= 1'b1;
          state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sm_mul.sv
// Scoreboard bench for seq_sm_mul: default, OUT_W=24 and FRAC_BITS=8 instances share stimulus
// pins; each has its own in_valid, and one monitor checks every handoff against queued results.
module tb_seq_sm_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] mag_a, mag_b;
  logic        sign_a, sign_b;
  logic [2:0]  iv, rdy, ov, sg, of;
  logic        out_ready;
  logic [63:0] o0, o2;
  logic [23:0] o1;
  logic [63:0] o [3];

  assign o[0] = o0;
  assign o[1] = {40'd0, o1};
  assign o[2] = o2;

  seq_sm_mul dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .mag_a(mag_a), .sign_a(sign_a), .mag_b(mag_b), .sign_b(sign_b),
    .out_valid(ov[0]), .out_ready(out_ready), .out(o0), .sign(sg[0]), .overflow(of[0])
  );

  seq_sm_mul #(.OUT_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .mag_a(mag_a), .sign_a(sign_a), .mag_b(mag_b), .sign_b(sign_b),
    .out_valid(ov[1]), .out_ready(out_ready), .out(o1), .sign(sg[1]), .overflow(of[1])
  );

  seq_sm_mul #(.FRAC_BITS(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
    .mag_a(mag_a), .sign_a(sign_a), .mag_b(mag_b), .sign_b(sign_b),
    .out_valid(ov[2]), .out_ready(out_ready), .out(o2), .sign(sg[2]), .overflow(of[2])
  );

  typedef struct {
    int          d;
    logic [63:0] res;
    logic        sgn;
    logic        ovf;
  } exp_t;

  exp_t scb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout, want event", name);
  endtask

  // Present operands to instance d and return 1 time unit after the accepting edge.
  task automatic issue(int d, logic sa, int a, logic sbb, int b,
                       logic [63:0] eres, logic esgn, logic eovf, bit push);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    if (push) begin
      e.d = d; e.res = eres; e.sgn = esgn; e.ovf = eovf;
      scb.push_back(e);
    end
    mag_a  = 15'(a);
    sign_a = sa;
    mag_b  = 15'(b);
    sign_b = sbb;
    iv[d]  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[d]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 iv[d] = 1'b0;
    if (!ok) bound_fail($sformatf("accept dut%0d", d));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (scb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (!ok) bound_fail("drain");
  endtask

  // Monitor: a result is consumed at the edge following a negedge with out_valid && out_ready.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && out_ready) begin
        if (scb.size() == 0 || scb[0].d != d) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result dut%0d: got 0x%0h, want none", d, o[d]);
        end else begin
          exp_t e;
          e = scb.pop_front();
          chk($sformatf("out dut%0d", d), o[d], e.res);
          chk($sformatf("sign dut%0d", d), 64'(sg[d]), 64'(e.sgn));
          chk($sformatf("overflow dut%0d", d), 64'(of[d]), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit seen;
    iv = '0; out_ready = 1'b1;
    mag_a = '0; mag_b = '0; sign_a = 1'b0; sign_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(rdy[0]), 64'd1);
    chk("reset out_valid", 64'(ov[0]), 64'd0);
    chk("reset out", o[0], 64'd0);
    chk("reset sign", 64'(sg[0]), 64'd0);
    chk("reset overflow", 64'(of[0]), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency: out_valid on the 16th edge after the accepting edge.
    issue(0, 1'b0, 3, 1'b1, 5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0, 1'b1);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (ov[0]) begin
        lat = i;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd16);
    drain();

    issue(0, 1'b1, 32767, 1'b1, 32767, 64'd1073676289, 1'b0, 1'b0, 1'b1);
    drain();
    issue(0, 1'b1, 0, 1'b1, 5, 64'd0, 1'b0, 1'b0, 1'b1);
    drain();
    issue(0, 1'b1, 7, 1'b0, 0, 64'd0, 1'b0, 1'b0, 1'b1);
    drain();

    // Hold in DONE for 10 cycles with out_ready low.
    out_ready = 1'b0;
    issue(0, 1'b0, 100, 1'b1, 200, 64'hFFFF_FFFF_FFFF_B1E0, 1'b1, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ov[0]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) bound_fail("hold out_valid");
    for (int i = 0; i < 10; i++) begin
      chk("hold out", o[0], 64'hFFFF_FFFF_FFFF_B1E0);
      chk("hold sign", 64'(sg[0]), 64'd1);
      chk("hold overflow", 64'(of[0]), 64'd0);
      chk("hold in_ready", 64'(rdy[0]), 64'd0);
      chk("hold out_valid", 64'(ov[0]), 64'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Input noise while busy must not disturb the captured operands.
    issue(0, 1'b0, 1234, 1'b0, 567, 64'd699678, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      iv[0]  = 1'($urandom);
      mag_a  = 15'($urandom);
      mag_b  = 15'($urandom);
      sign_a = 1'($urandom);
      sign_b = 1'($urandom);
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    drain();

    // Back-to-back: the next issue waits for in_ready while results drain.
    issue(0, 1'b0, 7, 1'b0, 9, 64'd63, 1'b0, 1'b0, 1'b1);
    issue(0, 1'b1, 12, 1'b0, 11, 64'hFFFF_FFFF_FFFF_FF7C, 1'b1, 1'b0, 1'b1);
    issue(0, 1'b0, 32767, 1'b0, 1, 64'd32767, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset during BUSY cycle 7 abandons the product.
    issue(0, 1'b0, 5, 1'b0, 5, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midreset in_ready", 64'(rdy[0]), 64'd1);
    chk("midreset out_valid", 64'(ov[0]), 64'd0);
    chk("midreset out", o[0], 64'd0);
    chk("midreset sign", 64'(sg[0]), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, 1'b0, 2, 1'b0, 21, 64'd42, 1'b0, 1'b0, 1'b1);
    drain();

    // OUT_W=24 instance.
    issue(1, 1'b0, 32767, 1'b1, 32767, 64'h80_0001, 1'b1, 1'b1, 1'b1);
    drain();
    issue(1, 1'b0, 1000, 1'b1, 1000, 64'hF0_BDC0, 1'b1, 1'b0, 1'b1);
    drain();
    issue(1, 1'b0, 4096, 1'b0, 2048, 64'h7F_FFFF, 1'b0, 1'b1, 1'b1);
    drain();

    // FRAC_BITS=8 instance.
    issue(2, 1'b0, 1000, 1'b0, 3, 64'd11, 1'b0, 1'b0, 1'b1);
    drain();
    issue(2, 1'b1, 1, 1'b0, 1, 64'd0, 1'b0, 1'b0, 1'b1);
    drain();
    issue(2, 1'b1, 1000, 1'b0, 3, 64'hFFFF_FFFF_FFFF_FFF5, 1'b1, 1'b0, 1'b1);
    drain();

    repeat (5) @(posedge clk);
    chk("scoreboard empty", 64'(scb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
